// File: rtl/kws_decision.sv
// Post-classifier decision stage for the keyword-spotting path. It smooths per-keyword
// hits over a sliding frame window, thresholds the winner and applies a refractory hold-off.
module kws_decision #(
  parameter int NUM_KEYWORDS = 10,
  parameter int WINDOW       = 8,
  parameter int HOLDOFF      = 16,
  parameter int IDX_W        = $clog2(NUM_KEYWORDS),
  parameter int CNT_W        = $clog2(WINDOW + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_KEYWORDS-1:0] kws_result,
  input  logic                    kws_valid,
  input  logic [CNT_W-1:0]        threshold,
  output logic                    det_valid,
  output logic [IDX_W-1:0]        det_index,
  output logic [CNT_W-1:0]        det_score,
  output logic                    holdoff_active
);

  localparam int HO_W = $clog2(HOLDOFF + 1);

  localparam logic [0:0] ST_ARMED   = 1'b0;
  localparam logic [0:0] ST_HOLDOFF = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [HO_W-1:0]  HO_ZERO  = {HO_W{1'b0}};
  localparam logic [HO_W-1:0]  HO_ONE   = HO_W'(1);
  localparam logic [HO_W-1:0]  HO_LOAD  = HO_W'(HOLDOFF);

  logic [WINDOW-1:0] hist_r     [NUM_KEYWORDS];
  logic [CNT_W-1:0]  cnt_r      [NUM_KEYWORDS];
  logic [WINDOW-1:0] hist_nxt_s [NUM_KEYWORDS];
  logic [CNT_W-1:0]  cnt_nxt_s  [NUM_KEYWORDS];

  logic [0:0]        state_r;
  logic [HO_W-1:0]   ho_cnt_r;
  logic              det_valid_r;
  logic [IDX_W-1:0]  det_index_r;
  logic [CNT_W-1:0]  det_score_r;
  logic              holdoff_r;

  logic [CNT_W-1:0]  best_cnt_s;
  logic [IDX_W-1:0]  best_idx_s;
  logic [CNT_W-1:0]  thr_eff_s;
  logic              hit_s;
  logic              clear_s;
  logic              fire_s;

  // Next history and incremental window count per keyword (current frame included).
  always_comb begin
    for (int k = 0; k < NUM_KEYWORDS; k++) begin
      hist_nxt_s[k] = {hist_r[k][WINDOW-2:0], kws_result[k]};
      cnt_nxt_s[k]  = cnt_r[k] + CNT_W'(kws_result[k]) - CNT_W'(hist_r[k][WINDOW-1]);
    end
  end

  // Winner search: strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_cnt_s = cnt_nxt_s[0];
    best_idx_s = {IDX_W{1'b0}};
    for (int k = 1; k < NUM_KEYWORDS; k++) begin
      if (cnt_nxt_s[k] > best_cnt_s) begin
        best_cnt_s = cnt_nxt_s[k];
        best_idx_s = IDX_W'(k);
      end else begin
        best_cnt_s = best_cnt_s;
        best_idx_s = best_idx_s;
      end
    end
  end

  // Effective threshold (zero behaves as one) and detection qualification.
  always_comb begin
    if (threshold == CNT_ZERO) begin
      thr_eff_s = CNT_ONE;
    end else begin
      thr_eff_s = threshold;
    end
    hit_s   = (best_cnt_s >= thr_eff_s);
    clear_s = rst | ~enable;
    fire_s  = kws_valid & (state_r == ST_ARMED) & hit_s;
  end

  // Histories, counts, hold-off FSM and registered detection outputs.
  always_ff @(posedge clk) begin
    if (clear_s) begin
      for (int k = 0; k < NUM_KEYWORDS; k++) begin
        hist_r[k] <= {WINDOW{1'b0}};
        cnt_r[k]  <= CNT_ZERO;
      end
      state_r     <= ST_ARMED;
      ho_cnt_r    <= HO_ZERO;
      det_valid_r <= 1'b0;
      det_index_r <= {IDX_W{1'b0}};
      det_score_r <= CNT_ZERO;
      holdoff_r   <= 1'b0;
    end else begin
      det_valid_r <= fire_s;
      if (kws_valid) begin
        case (state_r)
          ST_ARMED: begin
            if (hit_s) begin
              // The detecting frame is consumed, not carried into the next window.
              for (int k = 0; k < NUM_KEYWORDS; k++) begin
                hist_r[k] <= {WINDOW{1'b0}};
                cnt_r[k]  <= CNT_ZERO;
              end
              det_index_r <= best_idx_s;
              det_score_r <= best_cnt_s;
              ho_cnt_r    <= HO_LOAD;
              state_r     <= ST_HOLDOFF;
              holdoff_r   <= 1'b1;
            end else begin
              for (int k = 0; k < NUM_KEYWORDS; k++) begin
                hist_r[k] <= hist_nxt_s[k];
                cnt_r[k]  <= cnt_nxt_s[k];
              end
            end
          end
          ST_HOLDOFF: begin
            for (int k = 0; k < NUM_KEYWORDS; k++) begin
              hist_r[k] <= hist_nxt_s[k];
              cnt_r[k]  <= cnt_nxt_s[k];
            end
            ho_cnt_r <= ho_cnt_r - HO_ONE;
            if (ho_cnt_r == HO_ONE) begin
              state_r   <= ST_ARMED;
              holdoff_r <= 1'b0;
            end else begin
              state_r   <= ST_HOLDOFF;
              holdoff_r <= 1'b1;
            end
          end
          default: begin
            state_r   <= ST_ARMED;
            ho_cnt_r  <= HO_ZERO;
            holdoff_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign det_valid      = det_valid_r;
  assign det_index      = det_index_r;
  assign det_score      = det_score_r;
  assign holdoff_active = holdoff_r;

endmodule

// File: tb/tb_kws_decision.sv
// Directed self-checking bench for kws_decision with hand-computed expectations
// (WINDOW=8, HOLDOFF=16, NUM_KEYWORDS=10).
module tb_kws_decision;

  localparam int NK    = 10;
  localparam int IDX_W = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             enable;
  logic [NK-1:0]    kws_result;
  logic             kws_valid;
  logic [CNT_W-1:0] threshold;
  logic             det_valid;
  logic [IDX_W-1:0] det_index;
  logic [CNT_W-1:0] det_score;
  logic             holdoff_active;

  int checks_cnt = 0;
  int errors_cnt = 0;

  kws_decision #(
    .NUM_KEYWORDS(10),
    .WINDOW(8),
    .HOLDOFF(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .kws_result(kws_result),
    .kws_valid(kws_valid),
    .threshold(threshold),
    .det_valid(det_valid),
    .det_index(det_index),
    .det_score(det_score),
    .holdoff_active(holdoff_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame: present vector on the edge, then sample 1 ns after it.
  task automatic frame(input logic [NK-1:0] v);
    kws_valid  = 1'b1;
    kws_result = v;
    @(posedge clk);
    #1;
    kws_valid  = 1'b0;
    kws_result = '0;
  endtask

  // n frames of v; only the last may detect (when det is set).
  task automatic run_frames(input string tag, input logic [NK-1:0] v, input int n,
                            input bit det, input int idx, input int score);
    for (int i = 1; i <= n; i++) begin
      frame(v);
      if (det && i == n) begin
        check({tag, "_det"}, det_valid, 1);
        check({tag, "_idx"}, det_index, idx);
        check({tag, "_score"}, det_score, score);
        check({tag, "_hold"}, holdoff_active, 1);
      end else begin
        check({tag, "_nodet"}, det_valid, 0);
      end
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, det_valid, 0);
    check({tag, "_idx"}, det_index, 0);
    check({tag, "_score"}, det_score, 0);
    check({tag, "_hold"}, holdoff_active, 0);
  endtask

  task automatic clear_enable();
    enable = 1'b0;
    @(posedge clk);
    #1;
    enable = 1'b1;
    check_cleared("en_clear");
  endtask

  task automatic clear_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_cleared("rst_clear");
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b1;
    kws_valid  = 1'b1;
    kws_result = '1;
    threshold  = 4'd5;

    // Reset wins over a valid all-ones frame.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_cleared("reset");
    end
    rst        = 1'b0;
    kws_valid  = 1'b0;
    kws_result = '0;

    // Basic detect on the fifth frame of bit 3.
    run_frames("basic", 10'b00_0000_1000, 5, 1'b1, 3, 5);
    @(posedge clk);
    #1;
    check("pulse_width", det_valid, 0);
    check("index_held", det_index, 3);

    // Hold-off: 16 frames blocked, the 17th detects with a full window.
    for (int i = 1; i <= 16; i++) begin
      frame(10'b00_0000_1000);
      check("ho_nodet", det_valid, 0);
      check("ho_active", holdoff_active, (i < 16) ? 1 : 0);
      check("ho_idx_held", det_index, 3);
    end
    run_frames("after_ho", 10'b00_0000_1000, 1, 1'b1, 3, 8);
    clear_enable();

    // Tie between keywords 2 and 7 resolves to 2.
    run_frames("tie", 10'b00_1000_0100, 5, 1'b1, 2, 5);
    clear_enable();

    // Sliding window: count never reaches 5 in these patterns.
    for (int i = 0; i < 12; i++) begin
      frame((i >= 4 && i < 8) ? 10'b0 : 10'b00_0001_0000);
      check("slide1_nodet", det_valid, 0);
    end
    run_frames("flush1", 10'b0, 8, 1'b0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      frame((i >= 3 && i < 7) ? 10'b0 : 10'b00_0001_0000);
      check("slide2_nodet", det_valid, 0);
    end
    run_frames("flush2", 10'b0, 8, 1'b0, 0, 0);
    run_frames("slide_det", 10'b00_0001_0000, 5, 1'b1, 4, 5);
    clear_enable();

    // Mid-operation clear via enable, then via rst.
    run_frames("en_pre", 10'b00_0000_0010, 4, 1'b0, 0, 0);
    clear_enable();
    run_frames("en_post1", 10'b00_0000_0010, 1, 1'b0, 0, 0);
    run_frames("en_post4", 10'b00_0000_0010, 4, 1'b1, 1, 5);
    clear_enable();
    run_frames("rst_pre", 10'b00_0000_0010, 4, 1'b0, 0, 0);
    clear_rst();
    run_frames("rst_post1", 10'b00_0000_0010, 1, 1'b0, 0, 0);
    run_frames("rst_post4", 10'b00_0000_0010, 4, 1'b1, 1, 5);
    clear_enable();

    // Threshold 0 acts as 1: single frame detects.
    threshold = 4'd0;
    run_frames("thr0", 10'b10_0000_0000, 1, 1'b1, 9, 1);
    clear_enable();

    // Threshold above WINDOW never detects.
    threshold = 4'd9;
    run_frames("thr_hi", 10'b00_0000_0001, 12, 1'b0, 0, 0);
    check("thr_hi_hold", holdoff_active, 0);

    // Multi-hot with differing counts: keyword 6 leads keyword 0.
    clear_enable();
    threshold = 4'd3;
    run_frames("mh_a", 10'b00_0100_0000, 2, 1'b0, 0, 0);
    run_frames("mh_b", 10'b00_0100_0001, 1, 1'b1, 6, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
